register_load_arbiter: RTL

Shares one 4-bit load-enabled register among N requesters. Each requester raises REQ with its data on its DIN slice. The arbiter picks one winner, grants it, and drives the register's L and D ports for exactly one load cycle. It then acknowledges the winner. It sits directly in front of the 4-bit register and is the only driver of its L and D inputs.

---
 rtl/register_load_arbiter_pkg.sv | 9 +
 rtl/register_load_arbiter_if.sv | 14 +
 rtl/register_load_arbiter_rr_pick.sv | 25 ++
 rtl/register_load_arbiter.sv | 66 ++++++
 4 files changed

// File: rtl/register_load_arbiter_pkg.sv
// register_arb_pkg: shared state encoding, default sizes and one-hot helper for the register load arbiter
package register_arb_pkg;
  localparam int N_DEF = 4;
  localparam int W_DEF = 4;
  typedef enum logic [1:0] {IDLE, GRANT, LOAD} state_t;
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction
endpackage

// File: rtl/register_load_arbiter_if.sv
// register_load_arbiter_if: requester-side bundle (req/din in, gnt/ack/l/d/busy out)
interface register_load_arbiter_if
  import register_arb_pkg::*;
  #(parameter int N = N_DEF, parameter int W = W_DEF);
  logic [N-1:0] req;
  logic [N*W-1:0] din;
  logic [N-1:0] gnt;
  logic [N-1:0] ack;
  logic l;
  logic [W-1:0] d;
  logic busy;
  modport master (output req, din, input gnt, ack, l, d, busy);
  modport slave (input req, din, output gnt, ack, l, d, busy);
endinterface

// File: rtl/register_load_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting just above ptr, wrapping modulo N
module rr_pick #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          valid
);
  logic [PW-1:0] j;
  // Walk offsets from farthest to nearest so the nearest set request overwrites and wins
  always_comb begin
    idx = '0;
    valid = 1'b0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = PW'((int'(ptr) + k) % N);
      if (req[j]) begin
        idx = j;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/register_load_arbiter.sv
// register_load_arbiter: grants one requester and drives a shared register's L/D for one cycle; REGARB_FIXED_PRIO_EN selects fixed lowest-index priority
module register_load_arbiter
  import register_arb_pkg::*;
  #(parameter int N = N_DEF, parameter int W = W_DEF)
(
  input logic clk,
  input logic rst,
  register_load_arbiter_if.slave bus
);
  localparam int PW = $clog2(N);
  state_t state;
  logic [PW-1:0] win, ptr, pick;
  logic pick_v;
  logic [N-1:0] gnt, ack;
  logic l;
  logic [W-1:0] d;
  rr_pick #(.N(N), .PW(PW)) u_pick (.req(bus.req), .ptr(ptr), .idx(pick), .valid(pick_v));
`ifdef REGARB_FIXED_PRIO_EN
  assign ptr = PW'(N - 1);
`else
  // Pointer remembers the last requester actually loaded; withdrawn grants leave it alone
  always_ff @(posedge clk) begin
    if (rst) ptr <= PW'(N - 1);
    else if (state == LOAD) ptr <= win;
  end
`endif
  // Grant/load sequencer with registered strobes; reset abandons any grant or load
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      ack <= '0;
      l <= 1'b0;
      d <= '0;
      win <= '0;
    end else begin
      case (state)
        IDLE: if (pick_v) begin
          win <= pick;
          gnt <= N'(onehot(3'(pick)));
          state <= GRANT;
        end
        GRANT: if (bus.req[win]) begin
          d <= bus.din[int'(win)*W +: W];
          l <= 1'b1;
          ack <= gnt;
          state <= LOAD;
        end else begin
          gnt <= '0;
          state <= IDLE;
        end
        default: begin
          l <= 1'b0;
          ack <= '0;
          gnt <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
  assign bus.gnt = gnt;
  assign bus.ack = ack;
  assign bus.l = l;
  assign bus.d = d;
  assign bus.busy = state != IDLE;
endmodule
